// File: rtl/chip_invaders_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip_invaders_pkg
// Purpose  : Shared types and constants for the invaders game: screen size,
//            player-ship state encoding, sprite selectors and the 16x8
//            left-justified sprite bitmaps (MSB = leftmost pixel).
// Contents : SCREEN_W/SCREEN_H, ship_state_t, sprite_sel_t, bitmap_t,
//            SHIP_BITMAP, EXPLODE_BITMAP_A/B, bitmap_pixel().
// Revision : 1.0 - initial release
// ============================================================================
package chip_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODING = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } ship_state_t;

  typedef enum logic [1:0] {
    SPR_SHIP      = 2'd0,
    SPR_EXPLODE_A = 2'd1,
    SPR_EXPLODE_B = 2'd2,
    SPR_NONE      = 2'd3
  } sprite_sel_t;

  // Index 0 is the top row; each row is left-justified in 16 bits.
  typedef logic [0:7][15:0] bitmap_t;

  localparam bitmap_t SHIP_BITMAP = '{
    16'h0200, 16'h0700, 16'h0700, 16'h7FF0,
    16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8
  };

  localparam bitmap_t EXPLODE_BITMAP_A = '{
    16'h0880, 16'h8508, 16'h2020, 16'h0700,
    16'h1FC0, 16'h5FD0, 16'h3FE0, 16'hFFF8
  };

  localparam bitmap_t EXPLODE_BITMAP_B = '{
    16'h8208, 16'h1040, 16'h0200, 16'h4890,
    16'h0D80, 16'h3FE0, 16'h7FF0, 16'hFFF8
  };

  // Column 0 is the leftmost pixel, i.e. bit 15 of the row word.
  function automatic logic bitmap_pixel(input bitmap_t bm,
                                        input logic [2:0] row,
                                        input logic [3:0] col);
    return bm[row][4'd15 - col];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ship_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ship_ctrl_if
// Purpose  : Bundle of the player-ship controller's game-side signals.
// Ports    : master - drives v_sync, pix_x/pix_y, move_left/right, hit,
//                     new_game; observes ship status and pixel outputs.
//            slave  - the ship controller itself (opposite directions).
// Revision : 1.0 - initial release
// ============================================================================
interface ship_ctrl_if;

  logic       v_sync;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       move_left;
  logic       move_right;
  logic       hit;
  logic       new_game;
  logic [9:0] ship_x_pos;
  logic       ship_vulnerable;
  logic [2:0] lives;
  logic       game_over;
  logic       ship_on;
  logic       explode_on;

  modport master (
    output v_sync, pix_x, pix_y, move_left, move_right, hit, new_game,
    input  ship_x_pos, ship_vulnerable, lives, game_over, ship_on, explode_on
  );

  modport slave (
    input  v_sync, pix_x, pix_y, move_left, move_right, hit, new_game,
    output ship_x_pos, ship_vulnerable, lives, game_over, ship_on, explode_on
  );

endinterface
`default_nettype wire

// File: rtl/ship_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : ship_sprite_rom
// Purpose  : Combinational sprite pixel lookup, shared by ship and invader
//            renderers.
// Ports    : i_sel - sprite select
//            i_row - sprite row (0 = top)
//            i_col - sprite column (0 = leftmost)
//            o_bit - pixel value
// Revision : 1.0 - initial release
// ============================================================================
module ship_sprite_rom
  import chip_invaders_pkg::*;
(
  input  sprite_sel_t i_sel,
  input  logic [2:0]  i_row,
  input  logic [3:0]  i_col,
  output logic        o_bit
);

  always_comb begin
    o_bit = 1'b0;
    case (i_sel)
      SPR_SHIP:      o_bit = bitmap_pixel(SHIP_BITMAP,      i_row, i_col);
      SPR_EXPLODE_A: o_bit = bitmap_pixel(EXPLODE_BITMAP_A, i_row, i_col);
      SPR_EXPLODE_B: o_bit = bitmap_pixel(EXPLODE_BITMAP_B, i_row, i_col);
      default:       o_bit = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ship_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ship_ctrl
// Purpose  : Player-ship controller on the pixel clock. Moves the ship once
//            per frame (rising edge of v_sync) with edge clamping, tracks
//            lives, and sequences ALIVE -> EXPLODING -> RESPAWN -> ALIVE or
//            GAME_OVER. Renders registered ship/explosion pixels.
// Ports    : clk      - pixel clock
//            rst      - asynchronous active-high reset
//            ship_bus - ship_ctrl_if.slave (v_sync, beam position, player
//                       controls, hit/new_game in; position, vulnerability,
//                       lives, game_over, ship_on/explode_on out)
// Revision : 1.0 - initial release
// ============================================================================
module ship_ctrl #(
  parameter int SHIP_W         = 13,
  parameter int SHIP_H         = 8,
  parameter int SHIP_Y         = 440,
  parameter int SCREEN_W       = chip_invaders_pkg::SCREEN_W,
  parameter int SPEED          = 4,
  parameter int START_X        = 312,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 32,
  parameter int RESPAWN_FRAMES = 64,
  parameter int BLINK_SHIFT    = 3
) (
  input  wire logic    clk,
  input  wire logic    rst,
  ship_ctrl_if.slave   ship_bus
);

  import chip_invaders_pkg::*;

  localparam int c_max_x   = SCREEN_W - SHIP_W;
  localparam int c_cnt_max = (EXPLODE_FRAMES > RESPAWN_FRAMES) ?
                             EXPLODE_FRAMES : RESPAWN_FRAMES;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

  ship_state_t        r_state, w_state_nx;
  logic [9:0]         r_x, w_x_nx;
  logic [2:0]         r_lives, w_lives_nx;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nx;
  logic               r_vs_q;
  logic               w_tick;
  logic [9:0]         w_move_x;
  logic [10:0]        w_x11;
  logic [10:0]        w_sum;
  logic [9:0]         w_diff;
  logic               r_ship_on, r_explode_on;

  // ---------------------------------------------------------------------------
  // Frame tick. The delayed copy resets high so a v_sync already high when
  // reset releases does not produce a tick on the first cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vs_q <= 1'b1;
    else     r_vs_q <= ship_bus.v_sync;
  end

  assign w_tick = ship_bus.v_sync & ~r_vs_q;

  // ---------------------------------------------------------------------------
  // Clamped movement, evaluated in 11 bits so the right edge cannot wrap.
  // ---------------------------------------------------------------------------
  assign w_x11  = {1'b0, r_x};
  assign w_sum  = w_x11 + 11'(SPEED);
  assign w_diff = r_x - 10'(SPEED);

  always_comb begin
    w_move_x = r_x;
    if (ship_bus.move_left && !ship_bus.move_right) begin
      w_move_x = (w_x11 < 11'(SPEED)) ? 10'd0 : w_diff;
    end else if (ship_bus.move_right && !ship_bus.move_left) begin
      w_move_x = (w_sum > 11'(c_max_x)) ? 10'(c_max_x) : w_sum[9:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ALIVE;
      r_x     <= 10'(START_X);
      r_lives <= 3'(LIVES);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_lives <= w_lives_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. new_game overrides everything; a hit wins over the
  // frame move in ALIVE. Hits in any other state are simply dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_lives_nx = r_lives;
    w_cnt_nx   = r_cnt;
    if (ship_bus.new_game) begin
      w_state_nx = RESPAWN;
      w_x_nx     = 10'(START_X);
      w_lives_nx = 3'(LIVES);
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ALIVE: begin
          if (ship_bus.hit) begin
            w_state_nx = EXPLODING;
            w_lives_nx = r_lives - 3'd1;
            w_cnt_nx   = '0;
          end else if (w_tick) begin
            w_x_nx = w_move_x;
          end
        end
        EXPLODING: begin
          if (w_tick) begin
            if (r_cnt == c_cnt_w'(EXPLODE_FRAMES - 1)) begin
              w_state_nx = (r_lives == 3'd0) ? GAME_OVER : RESPAWN;
              w_x_nx     = 10'(START_X);
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        end
        RESPAWN: begin
          if (w_tick) begin
            w_x_nx = w_move_x;
            if (r_cnt == c_cnt_w'(RESPAWN_FRAMES - 1)) begin
              w_state_nx = ALIVE;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        end
        default: ;  // GAME_OVER waits for new_game
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rendering: box test against the current ship position, one sprite lookup
  // whose bitmap depends on the state, then a registered output stage.
  // ---------------------------------------------------------------------------
  logic [10:0] w_px, w_py;
  logic        w_in_box;
  logic [3:0]  w_col;
  logic [2:0]  w_row;
  sprite_sel_t w_sel;
  logic        w_bit;

  assign w_px     = {1'b0, ship_bus.pix_x};
  assign w_py     = {1'b0, ship_bus.pix_y};
  assign w_in_box = (w_px >= w_x11) && (w_px < w_x11 + 11'(SHIP_W)) &&
                    (w_py >= 11'(SHIP_Y)) && (w_py < 11'(SHIP_Y + SHIP_H));
  assign w_col    = 4'(w_px - w_x11);
  assign w_row    = 3'(w_py - 11'(SHIP_Y));

  // Explosion animation flips between its two frames every 4 frames.
  always_comb begin
    w_sel = SPR_SHIP;
    if (r_state == EXPLODING) begin
      if (r_cnt[2]) w_sel = SPR_EXPLODE_B;
      else          w_sel = SPR_EXPLODE_A;
    end
  end

  ship_sprite_rom u_rom (
    .i_sel (w_sel),
    .i_row (w_row),
    .i_col (w_col),
    .o_bit (w_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ship_on    <= 1'b0;
      r_explode_on <= 1'b0;
    end else begin
      r_ship_on    <= w_in_box && w_bit &&
                      ((r_state == ALIVE) ||
                       ((r_state == RESPAWN) && !r_cnt[BLINK_SHIFT]));
      r_explode_on <= w_in_box && w_bit && (r_state == EXPLODING);
    end
  end

  assign ship_bus.ship_x_pos      = r_x;
  assign ship_bus.ship_vulnerable = (r_state == ALIVE);
  assign ship_bus.lives           = r_lives;
  assign ship_bus.game_over       = (r_state == GAME_OVER);
  assign ship_bus.ship_on         = r_ship_on;
  assign ship_bus.explode_on      = r_explode_on;

endmodule
`default_nettype wire

// File: tb/tb_ship_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_ctrl
// Purpose  : Self-checking bench for ship_ctrl. A frame-level reference model
//            (position, lives, phase, frames-in-phase) and text images of the
//            sprites supply every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_ctrl;

  localparam int SPEED = 4, START_X = 312, MAXX = 640 - 13, LIVES = 3;
  localparam int EF = 32, RF = 64, BS = 3, SY = 440, SW = 13, SH = 8;
  localparam int M_ALIVE = 0, M_EXPL = 1, M_RESP = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ship_ctrl_if sif ();

  ship_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ship_bus (sif)
  );

  string ship_img [8] = '{
    "......X......", ".....XXX.....", ".....XXX.....", ".XXXXXXXXXXX.",
    "XXXXXXXXXXXXX", "XXXXXXXXXXXXX", "XXXXXXXXXXXXX", "XXXXXXXXXXXXX"};
  string expa_img [8] = '{
    "....X...X....", "X....X.X....X", "..X.......X..", ".....XXX.....",
    "...XXXXXXX...", ".X.XXXXXXX.X.", "..XXXXXXXXX..", "XXXXXXXXXXXXX"};
  string expb_img [8] = '{
    "X.....X.....X", "...X.....X...", "......X......", ".X..X...X..X.",
    "....XX.XX....", "..XXXXXXXXX..", ".XXXXXXXXXXX.", "XXXXXXXXXXXXX"};

  int n_tests = 0;
  int n_fail  = 0;

  int m_state, m_x, m_lives, m_phase;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_state = M_ALIVE; m_x = START_X; m_lives = LIVES; m_phase = 0;
  endfunction

  function automatic void model_new_game();
    m_state = M_RESP; m_x = START_X; m_lives = LIVES; m_phase = 0;
  endfunction

  function automatic void model_hit();
    if (m_state == M_ALIVE) begin
      m_state = M_EXPL; m_lives = m_lives - 1; m_phase = 0;
    end
  endfunction

  function automatic void model_frame(input bit l, input bit r);
    if (m_state == M_ALIVE || m_state == M_RESP) begin
      if (l && !r)      m_x = (m_x - SPEED < 0) ? 0 : m_x - SPEED;
      else if (r && !l) m_x = (m_x + SPEED > MAXX) ? MAXX : m_x + SPEED;
    end
    if (m_state == M_RESP) begin
      m_phase++;
      if (m_phase == RF) begin m_state = M_ALIVE; m_phase = 0; end
    end else if (m_state == M_EXPL) begin
      m_phase++;
      if (m_phase == EF) begin
        m_state = (m_lives == 0) ? M_OVER : M_RESP;
        m_x = START_X; m_phase = 0;
      end
    end
  endfunction

  function automatic void model_pix(input int px, input int py,
                                    output bit s, output bit e);
    int    r, c;
    string row;
    s = 1'b0; e = 1'b0;
    if (px < m_x || px >= m_x + SW || py < SY || py >= SY + SH) return;
    r = py - SY; c = px - m_x;
    row = ship_img[r];
    if (m_state == M_ALIVE) s = (row[c] == "X");
    if (m_state == M_RESP)  s = (row[c] == "X") && (((m_phase / (1 << BS)) % 2) == 0);
    if (m_state == M_EXPL) begin
      row = (((m_phase / 4) % 2) == 0) ? expa_img[r] : expb_img[r];
      e = (row[c] == "X");
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_x"},     32'(sif.ship_x_pos),      32'(m_x));
    chk({tag, "_lives"}, 32'(sif.lives),           32'(m_lives));
    chk({tag, "_over"},  32'(sif.game_over),       32'(m_state == M_OVER));
    chk({tag, "_vuln"},  32'(sif.ship_vulnerable), 32'(m_state == M_ALIVE));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit l, input bit r, input int hi);
    sif.move_left = l; sif.move_right = r; sif.v_sync = 1'b1;
    step();
    model_frame(l, r);
    repeat (hi - 1) step();
    sif.v_sync = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_hit();
    sif.hit = 1'b1; step(); sif.hit = 1'b0;
    model_hit();
  endtask

  task automatic probe(input int px, input int py, input string tag);
    bit es, ee;
    sif.pix_x = 10'(px); sif.pix_y = 10'(py);
    step();
    model_pix(px, py, es, ee);
    chk({tag, "_ship_on"},    32'(sif.ship_on),    32'(es));
    chk({tag, "_explode_on"}, 32'(sif.explode_on), 32'(ee));
  endtask

  task automatic rand_probe(input string tag);
    int px, py;
    px = m_x + int'($urandom_range(0, 16)) - 2;
    if (px < 0) px = 0;
    py = SY - 2 + int'($urandom_range(0, 11));
    probe(px, py, tag);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    sif.v_sync = 1'b1; sif.pix_x = '0; sif.pix_y = '0;
    sif.move_left = 1'b0; sif.move_right = 1'b1;
    sif.hit = 1'b0; sif.new_game = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    chk_status("reset");
    chk("reset_ship_on",    32'(sif.ship_on),    32'd0);
    chk("reset_explode_on", 32'(sif.explode_on), 32'd0);
    rst = 1'b0;
    // v_sync already high at reset release: no tick may follow
    repeat (3) step();
    chk_status("no_tick_after_reset");
    sif.v_sync = 1'b0; step(); step();

    // Right for 80 frames: saturates at 627
    for (int i = 0; i < 80; i++) begin
      frame(1'b0, 1'b1, 1 + int'($urandom_range(0, 3)));
      chk("right_x", 32'(sif.ship_x_pos), 32'(m_x));
    end
    chk("right_sat", 32'(sif.ship_x_pos), 32'd627);

    // Left until clamped at 0 and beyond (no wrap)
    for (int i = 0; i < 170; i++) begin
      frame(1'b1, 1'b0, 1);
      chk("left_x", 32'(sif.ship_x_pos), 32'(m_x));
    end
    chk("left_sat", 32'(sif.ship_x_pos), 32'd0);

    // Random movement with random probes
    for (int i = 0; i < 40; i++) begin
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1 + int'($urandom_range(0, 3)));
      chk_status("rand_move");
      rand_probe("rand_alive");
    end

    // Both held: no motion; long v_sync high: one move
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, 2);
    chk_status("both_held");
    frame((m_x >= SPEED) ? 1'b1 : 1'b0, (m_x >= SPEED) ? 1'b0 : 1'b1, 25);
    chk_status("long_vsync");

    // Navigate to x = 100 and probe the sprite
    for (int i = 0; i < 200 && m_x != 0; i++) frame(1'b1, 1'b0, 1);
    for (int i = 0; i < 25; i++) frame(1'b0, 1'b1, 1);
    chk("at_100", 32'(sif.ship_x_pos), 32'd100);
    probe(106, 440, "p106_440"); chk("p106_440_c", 32'(sif.ship_on), 32'd1);
    probe(100, 440, "p100_440"); chk("p100_440_c", 32'(sif.ship_on), 32'd0);
    probe(100, 444, "p100_444"); chk("p100_444_c", 32'(sif.ship_on), 32'd1);
    probe(113, 444, "p113_444"); chk("p113_444_c", 32'(sif.ship_on), 32'd0);
    probe(99, 447, "p99_447");
    probe(112, 447, "p112_447");
    probe(106, 448, "p106_448");
    for (int i = 0; i < 20; i++) rand_probe("rand_box");

    // First hit
    pulse_hit();
    chk_status("hit1");
    chk("hit1_lives_c", 32'(sif.lives), 32'd2);
    probe(m_x, 447, "expl_row7");
    chk("expl_row7_c", 32'(sif.explode_on), 32'd1);
    for (int i = 0; i < EF; i++) begin
      rand_probe("expl");
      frame(1'b0, 1'b1, 1);
      chk_status("expl_frame");
    end
    chk("respawn_x", 32'(sif.ship_x_pos), 32'd312);

    // Respawn: blink, ignored hits, movement allowed
    for (int i = 0; i < RF; i++) begin
      probe(m_x + 6, 440, "blink");
      if (i == 10 || i == 40) pulse_hit();
      frame(1'($urandom_range(0, 1)), 1'b0, 1);
      chk_status("resp_frame");
    end
    chk("alive_again", 32'(sif.ship_vulnerable), 32'd1);

    // Second hit coincident with frame tick: hit wins, no move
    sif.hit = 1'b1; sif.v_sync = 1'b1;
    sif.move_left = 1'b0; sif.move_right = (m_x < MAXX);
    sif.move_left = (m_x == MAXX);
    step();
    model_hit();
    sif.hit = 1'b0; step(); sif.v_sync = 1'b0; step(); step();
    chk_status("hit_tick");
    for (int i = 0; i < EF; i++) frame(1'b0, 1'b0, 1);
    for (int i = 0; i < RF; i++) frame(1'b0, 1'b0, 1);
    chk_status("after_hit2");

    // Third hit -> game over
    pulse_hit();
    for (int i = 0; i < EF; i++) frame(1'b0, 1'b0, 1);
    chk_status("game_over");
    chk("game_over_c", 32'(sif.game_over), 32'd1);
    chk("game_over_lives_c", 32'(sif.lives), 32'd0);
    probe(m_x + 6, 444, "over_pix");
    pulse_hit();
    frame(1'b0, 1'b1, 1);
    chk_status("over_hit_ignored");

    // New game
    sif.new_game = 1'b1; step(); sif.new_game = 1'b0;
    model_new_game();
    chk_status("new_game");
    chk("new_game_lives_c", 32'(sif.lives), 32'd3);
    for (int i = 0; i < RF; i++) frame(1'b0, 1'b0, 1);
    chk_status("ng_alive");

    // Reset in the middle of an explosion
    pulse_hit();
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0, 1);
    probe(m_x, 447, "pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    chk_status("mid_rst");
    chk("mid_rst_ship_on",    32'(sif.ship_on),    32'd0);
    chk("mid_rst_explode_on", 32'(sif.explode_on), 32'd0);
    step();
    rst = 1'b0;
    step(); step();

    // Simultaneous hit and new_game in ALIVE
    sif.hit = 1'b1; sif.new_game = 1'b1; step();
    sif.hit = 1'b0; sif.new_game = 1'b0;
    model_new_game();
    chk_status("hit_and_ng");
    chk("hit_and_ng_lives_c", 32'(sif.lives), 32'd3);
    probe(m_x + 6, 440, "hit_and_ng_pix");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
